// File: rtl/cn_scratch_ctrl.sv
// rtl/cn_scratch_ctrl.sv - Banked scratchpad controller with fill engine, run handshake and status registers
//
// cn_scratch_bank : one 128-bit synchronous RAM bank, 1-cycle registered read.
//   clk_i, we_i, re_i, addr_i, wdata_i -> rdata_o
//
// cn_scratch_ctrl : owns NBANKS banks and hands them to the host (IDLE),
//                   the fill engine (FILL) or the memory-loop core (RUN).
//   clk, reset_n                  clock, asynchronous active-low reset
//   mem_address/write/read/wrdata host word port; low BSEL address bits pick the bank
//   mem_waitrequest               high whenever the host does not own the RAM
//   mem_rddata/mem_rddatavalid    host read data, returned two cycles after acceptance
//   reg_address/write/wrdata      register write port
//   reg_rddata                    registered register read data
//   core_start/core_running       run handshake towards the core
//   core_finished                 completion pulse from the core
//   core_ram_*                    full-width core RAM port, all banks in parallel

module cn_scratch_bank #(
  parameter int AW = 15
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [127:0]  wdata_i,
  output logic [127:0]  rdata_o
);

  logic [127:0] mem_q [0:(1<<AW)-1];
  logic [127:0] rdata_q;

  // Plain RAM macro behaviour: no reset on contents or read register.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

module cn_scratch_ctrl #(
  parameter int          ADDR_WIDTH = 15,
  parameter int          NBANKS     = 4,
  parameter logic [31:0] VERSION    = 32'h19080100
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [ADDR_WIDTH+$clog2(NBANKS)-1:0] mem_address,
  input  logic                                 mem_write,
  input  logic                                 mem_read,
  input  logic [127:0]                         mem_wrdata,
  output logic                                 mem_waitrequest,
  output logic [127:0]                         mem_rddata,
  output logic                                 mem_rddatavalid,
  input  logic [9:0]                           reg_address,
  input  logic                                 reg_write,
  input  logic [31:0]                          reg_wrdata,
  output logic [31:0]                          reg_rddata,
  output logic                                 core_start,
  output logic                                 core_running,
  input  logic                                 core_finished,
  input  logic                                 core_ram_re,
  input  logic                                 core_ram_we,
  input  logic [ADDR_WIDTH-1:0]                core_ram_addr,
  input  logic [NBANKS*128-1:0]                core_ram_wrdata,
  output logic [NBANKS*128-1:0]                core_ram_rddata
);

  localparam int BSEL = $clog2(NBANKS);
  localparam int BW   = (BSEL > 0) ? BSEL : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] fill_cnt_q, fill_cnt_d;
  logic [31:0]           fill_lo_q, fill_lo_d;
  logic [31:0]           fill_hi_q, fill_hi_d;
  logic [31:0]           cycles_q, cycles_d;
  logic                  done_q, done_d;
  logic                  fill_done_q, fill_done_d;
  logic                  err_q, err_d;
  logic                  core_start_q, core_start_d;
  logic                  rd_vld1_q;
  logic [BW-1:0]         rd_bsel_q;
  logic                  mem_rddatavalid_q;
  logic [127:0]          mem_rddata_q;
  logic [31:0]           reg_rddata_q, reg_rddata_d;

  logic                  is_idle;
  logic                  ctrl_wr, wr_start, wr_fill, wr_clr;
  logic                  host_rd_acc, host_wr_acc;
  logic [BW-1:0]         host_bank;
  logic [ADDR_WIDTH-1:0] host_row;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [127:0]          fill_word;
  logic [127:0]          rd_sel_data;
  logic [31:0]           status;

  assign is_idle     = (state_q == S_IDLE);
  assign ctrl_wr     = reg_write && (reg_address == 10'h000);
  assign wr_start    = ctrl_wr && reg_wrdata[0];
  assign wr_fill     = ctrl_wr && reg_wrdata[1];
  assign wr_clr      = ctrl_wr && reg_wrdata[2];
  assign host_rd_acc = mem_read && is_idle;
  assign host_wr_acc = mem_write && is_idle;
  assign fill_word   = {fill_hi_q, fill_lo_q, fill_hi_q, fill_lo_q};

  generate
    if (BSEL > 0) begin : g_bsel
      assign host_bank = mem_address[BSEL-1:0];
      assign host_row  = mem_address[ADDR_WIDTH+BSEL-1:BSEL];
    end else begin : g_nobsel
      assign host_bank = 1'b0;
      assign host_row  = mem_address;
    end
  endgenerate

  // All banks share one row address; only the write enables differ per bank.
  always_comb begin
    ram_addr = host_row;
    case (state_q)
      S_FILL:  ram_addr = fill_cnt_q;
      S_RUN:   ram_addr = core_ram_addr;
      default: ram_addr = host_row;
    endcase
  end

  for (genvar k = 0; k < NBANKS; k++) begin : g_bank
    logic         we;
    logic         re;
    logic [127:0] wdata;

    always_comb begin
      we    = 1'b0;
      re    = 1'b0;
      wdata = mem_wrdata;
      case (state_q)
        S_IDLE: begin
          we = host_wr_acc && (host_bank == BW'(k));
          re = host_rd_acc;
        end
        S_FILL: begin
          we    = 1'b1;
          wdata = fill_word;
        end
        S_RUN: begin
          we    = core_ram_we;
          re    = core_ram_re;
          wdata = core_ram_wrdata[128*k +: 128];
        end
        default: ;
      endcase
    end

    cn_scratch_bank #(.AW(ADDR_WIDTH)) u_bank (
      .clk_i   (clk),
      .we_i    (we),
      .re_i    (re),
      .addr_i  (ram_addr),
      .wdata_i (wdata),
      .rdata_o (core_ram_rddata[128*k +: 128])
    );
  end

  // Bank select travels one stage behind the RAM read so the mux picks the
  // bank of the read that produced the data, not the current address.
  assign rd_sel_data = core_ram_rddata[{rd_bsel_q, 7'd0} +: 128];

  always_comb begin
    state_d      = state_q;
    fill_cnt_d   = fill_cnt_q;
    fill_lo_d    = fill_lo_q;
    fill_hi_d    = fill_hi_q;
    cycles_d     = cycles_q;
    done_d       = done_q;
    fill_done_d  = fill_done_q;
    err_d        = err_q;
    core_start_d = 1'b0;

    // Clear first so a sticky bit raised by the same write still lands.
    if (wr_clr) begin
      done_d      = 1'b0;
      fill_done_d = 1'b0;
      err_d       = 1'b0;
    end
    if (reg_write && (reg_address == 10'h002)) fill_lo_d = reg_wrdata;
    if (reg_write && (reg_address == 10'h003)) fill_hi_d = reg_wrdata;

    case (state_q)
      S_IDLE: begin
        if (wr_fill) begin
          state_d    = S_FILL;
          fill_cnt_d = '0;
          if (wr_start) err_d = 1'b1;
        end else if (wr_start) begin
          state_d      = S_RUN;
          cycles_d     = '0;
          core_start_d = 1'b1;
        end
      end
      S_FILL: begin
        if (wr_start || wr_fill) err_d = 1'b1;
        if (&fill_cnt_q) begin
          state_d     = S_IDLE;
          fill_done_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (wr_start || wr_fill) err_d = 1'b1;
        if (cycles_q != 32'hFFFF_FFFF) cycles_d = cycles_q + 32'd1;
        if (core_finished) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign status = {26'd0, state_q, err_q, fill_done_q, done_q, !is_idle};

  always_comb begin
    reg_rddata_d = 32'h1234_5678;
    case (reg_address)
      10'h000: reg_rddata_d = 32'd0;
      10'h001: reg_rddata_d = status;
      10'h002: reg_rddata_d = fill_lo_q;
      10'h003: reg_rddata_d = fill_hi_q;
      10'h004: reg_rddata_d = cycles_q;
      10'h200: reg_rddata_d = VERSION;
      default: reg_rddata_d = 32'h1234_5678;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q           <= S_IDLE;
      fill_cnt_q        <= '0;
      fill_lo_q         <= '0;
      fill_hi_q         <= '0;
      cycles_q          <= '0;
      done_q            <= 1'b0;
      fill_done_q       <= 1'b0;
      err_q             <= 1'b0;
      core_start_q      <= 1'b0;
      rd_vld1_q         <= 1'b0;
      rd_bsel_q         <= '0;
      mem_rddatavalid_q <= 1'b0;
      mem_rddata_q      <= '0;
      reg_rddata_q      <= '0;
    end else begin
      state_q           <= state_d;
      fill_cnt_q        <= fill_cnt_d;
      fill_lo_q         <= fill_lo_d;
      fill_hi_q         <= fill_hi_d;
      cycles_q          <= cycles_d;
      done_q            <= done_d;
      fill_done_q       <= fill_done_d;
      err_q             <= err_d;
      core_start_q      <= core_start_d;
      rd_vld1_q         <= host_rd_acc;
      rd_bsel_q         <= host_bank;
      mem_rddatavalid_q <= rd_vld1_q;
      if (rd_vld1_q) mem_rddata_q <= rd_sel_data;
      reg_rddata_q      <= reg_rddata_d;
    end
  end

  assign mem_waitrequest = !is_idle;
  assign mem_rddata      = mem_rddata_q;
  assign mem_rddatavalid = mem_rddatavalid_q;
  assign reg_rddata      = reg_rddata_q;
  assign core_start      = core_start_q;
  assign core_running    = (state_q == S_RUN);

endmodule
